// File: rtl/mac_pe_ws_param.sv
// Weight-stationary MAC processing element with a shadow weight, a valid-tagged partial-sum chain
// and a selectable signed or unsigned feature input. Define MAC_SAT_EN for saturating adds with a sticky ovf_o.
module mac_pe_ws_param #(
    parameter int X_W      = 8,
    parameter int W_W      = 8,
    parameter int ACC_W    = 32,
    parameter int X_SIGNED = 0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             en_x_i,
    input  logic             en_w_i,
    input  logic             swap_w_i,
    input  logic             stop_mac_i,
    input  logic             used_row_i,
    input  logic [X_W-1:0]   x_i,
    input  logic [W_W-1:0]   w_i,
    input  logic [ACC_W-1:0] before_sum_i,
    input  logic             sum_valid_i,
    output logic [X_W-1:0]   x_o,
    output logic             en_x_o,
    output logic [W_W-1:0]   w_o,
    output logic             en_w_o,
    output logic             swap_w_o,
    output logic             stop_mac_o,
    output logic             used_row_o,
    output logic [ACC_W-1:0] after_sum_o,
    output logic             sum_valid_o,
    output logic             ovf_o
);

    localparam int P_W = X_W + W_W + 1;
    localparam int S_W = ACC_W + 1;

    logic [X_W-1:0]   x_reg;
    logic [W_W-1:0]   w_reg;
    logic             en_x_reg;
    logic             en_w_reg;
    logic             swap_w_reg;
    logic [W_W-1:0]   shadow_w_reg;
    logic [W_W-1:0]   active_w_reg;
    logic             used_row_reg;
    logic             stop_mac_reg;
    logic [ACC_W-1:0] sum_reg;
    logic             sum_valid_reg;

    logic [X_W:0]            x_ext;
    logic signed [P_W-1:0]   w_full;
    logic signed [P_W-1:0]   x_full;
    logic signed [P_W-1:0]   product;
    logic [S_W-1:0]          sum_wide;
    logic [ACC_W-1:0]        sum_next;
    logic                    mac_go;

    generate
        if (X_SIGNED != 0) begin : g_x_signed
            assign x_ext = {x_i[X_W-1], x_i};
        end else begin : g_x_unsigned
            assign x_ext = {1'b0, x_i};
        end
    endgenerate

    // Both operands widened to the full product width so the multiply is exact.
    assign w_full   = {{(P_W-W_W){active_w_reg[W_W-1]}}, active_w_reg};
    assign x_full   = {{(P_W-X_W-1){x_ext[X_W]}}, x_ext};
    assign product  = w_full * x_full;
    assign sum_wide = {before_sum_i[ACC_W-1], before_sum_i}
                    + {{(S_W-P_W){product[P_W-1]}}, product};

    // A swap cycle never accumulates: the incoming weight only takes effect on the next cycle.
    assign mac_go = !swap_w_i && !stop_mac_reg && used_row_reg && en_x_i && sum_valid_i;

`ifdef MAC_SAT_EN
    logic clamp;
    logic ovf_reg;

    assign clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_next = clamp ? {sum_wide[ACC_W], {(ACC_W-1){~sum_wide[ACC_W]}}}
                            : sum_wide[ACC_W-1:0];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ovf_reg <= 1'b0;
        end else if (swap_w_i) begin
            ovf_reg <= 1'b0;
        end else if (mac_go && clamp) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf_o = ovf_reg;
`else
    logic unused_sum_msb;

    assign unused_sum_msb = sum_wide[ACC_W];
    assign sum_next       = sum_wide[ACC_W-1:0];
    assign ovf_o          = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            x_reg         <= '0;
            w_reg         <= '0;
            en_x_reg      <= 1'b0;
            en_w_reg      <= 1'b0;
            swap_w_reg    <= 1'b0;
            shadow_w_reg  <= '0;
            active_w_reg  <= '0;
            used_row_reg  <= 1'b0;
            stop_mac_reg  <= 1'b0;
            sum_reg       <= '0;
            sum_valid_reg <= 1'b0;
        end else begin
            x_reg        <= x_i;
            w_reg        <= w_i;
            en_x_reg     <= en_x_i;
            en_w_reg     <= en_w_i;
            swap_w_reg   <= swap_w_i;
            stop_mac_reg <= stop_mac_i;
            if (en_w_i) begin
                shadow_w_reg <= w_i;
            end
            if (swap_w_i) begin
                active_w_reg <= en_w_i ? w_i : shadow_w_reg;
                used_row_reg <= used_row_i;
            end
            sum_reg       <= mac_go ? sum_next : '0;
            sum_valid_reg <= mac_go;
        end
    end

    assign x_o         = x_reg;
    assign w_o         = w_reg;
    assign en_x_o      = en_x_reg;
    assign en_w_o      = en_w_reg;
    assign swap_w_o    = swap_w_reg;
    assign stop_mac_o  = stop_mac_reg;
    assign used_row_o  = used_row_reg;
    assign after_sum_o = sum_reg;
    assign sum_valid_o = sum_valid_reg;

endmodule

// File: tb/tb_mac_pe_ws_param.sv
// Directed bench for mac_pe_ws_param: three instances (unsigned x, signed x, 16-bit accumulator)
// share one stimulus stream; expected values are hand-computed constants.
module tb_mac_pe_ws_param;

`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        en_x_i = 1'b0, en_w_i = 1'b0, swap_w_i = 1'b0;
    logic        stop_mac_i = 1'b0, used_row_i = 1'b0, sum_valid_i = 1'b0;
    logic [7:0]  x_i = '0;
    logic [7:0]  w_i = '0;
    logic [31:0] before_sum_i = '0;

    logic [7:0]         x_o_u, w_o_u, x_o_s, w_o_s, x_o_n, w_o_n;
    logic               en_x_o_u, en_w_o_u, swap_w_o_u, stop_mac_o_u, used_row_o_u, sum_valid_o_u, ovf_o_u;
    logic               en_x_o_s, en_w_o_s, swap_w_o_s, stop_mac_o_s, used_row_o_s, sum_valid_o_s, ovf_o_s;
    logic               en_x_o_n, en_w_o_n, swap_w_o_n, stop_mac_o_n, used_row_o_n, sum_valid_o_n, ovf_o_n;
    logic signed [31:0] after_sum_o_u, after_sum_o_s;
    logic signed [15:0] after_sum_o_n;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    mac_pe_ws_param #(.X_W(8), .W_W(8), .ACC_W(32), .X_SIGNED(0)) dut_u (
        .CLK(CLK), .RSTN(RSTN), .en_x_i(en_x_i), .en_w_i(en_w_i), .swap_w_i(swap_w_i),
        .stop_mac_i(stop_mac_i), .used_row_i(used_row_i), .x_i(x_i), .w_i(w_i),
        .before_sum_i(before_sum_i), .sum_valid_i(sum_valid_i),
        .x_o(x_o_u), .en_x_o(en_x_o_u), .w_o(w_o_u), .en_w_o(en_w_o_u), .swap_w_o(swap_w_o_u),
        .stop_mac_o(stop_mac_o_u), .used_row_o(used_row_o_u), .after_sum_o(after_sum_o_u),
        .sum_valid_o(sum_valid_o_u), .ovf_o(ovf_o_u)
    );

    mac_pe_ws_param #(.X_W(8), .W_W(8), .ACC_W(32), .X_SIGNED(1)) dut_s (
        .CLK(CLK), .RSTN(RSTN), .en_x_i(en_x_i), .en_w_i(en_w_i), .swap_w_i(swap_w_i),
        .stop_mac_i(stop_mac_i), .used_row_i(used_row_i), .x_i(x_i), .w_i(w_i),
        .before_sum_i(before_sum_i), .sum_valid_i(sum_valid_i),
        .x_o(x_o_s), .en_x_o(en_x_o_s), .w_o(w_o_s), .en_w_o(en_w_o_s), .swap_w_o(swap_w_o_s),
        .stop_mac_o(stop_mac_o_s), .used_row_o(used_row_o_s), .after_sum_o(after_sum_o_s),
        .sum_valid_o(sum_valid_o_s), .ovf_o(ovf_o_s)
    );

    mac_pe_ws_param #(.X_W(8), .W_W(8), .ACC_W(16), .X_SIGNED(0)) dut_n (
        .CLK(CLK), .RSTN(RSTN), .en_x_i(en_x_i), .en_w_i(en_w_i), .swap_w_i(swap_w_i),
        .stop_mac_i(stop_mac_i), .used_row_i(used_row_i), .x_i(x_i), .w_i(w_i),
        .before_sum_i(before_sum_i[15:0]), .sum_valid_i(sum_valid_i),
        .x_o(x_o_n), .en_x_o(en_x_o_n), .w_o(w_o_n), .en_w_o(en_w_o_n), .swap_w_o(swap_w_o_n),
        .stop_mac_o(stop_mac_o_n), .used_row_o(used_row_o_n), .after_sum_o(after_sum_o_n),
        .sum_valid_o(sum_valid_o_n), .ovf_o(ovf_o_n)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_sum_u", after_sum_o_u, 0);
        check("rst_valid_u", sum_valid_o_u, 0);
        check("rst_x_o", x_o_u, 0);
        check("rst_used_row", used_row_o_u, 0);
        check("rst_ovf_n", ovf_o_n, 0);
        RSTN = 1'b1;

        // Load -3 into shadow, then swap with used_row
        en_w_i = 1; w_i = 8'hFD;
        tick();
        check("fwd_w_o", w_o_u, 8'hFD);
        check("fwd_en_w_o", en_w_o_u, 1);
        en_w_i = 0; swap_w_i = 1; used_row_i = 1;
        tick();
        check("swap_valid", sum_valid_o_u, 0);
        check("swap_used_row", used_row_o_u, 1);
        check("fwd_swap_o", swap_w_o_u, 1);
        swap_w_i = 0; x_i = 8'd200; before_sum_i = 32'd10; en_x_i = 1; sum_valid_i = 1;
        tick();
        check("u_200xm3", after_sum_o_u, -590);
        check("u_valid", sum_valid_o_u, 1);
        check("s_m56xm3", after_sum_o_s, 178);
        check("n_200xm3", after_sum_o_n, -590);

        // Bypass load+swap of 5, signed feature -10
        en_w_i = 1; w_i = 8'd5; swap_w_i = 1; en_x_i = 0;
        tick();
        check("bypass_valid", sum_valid_o_s, 0);
        en_w_i = 0; swap_w_i = 0; x_i = 8'hF6; before_sum_i = 0; en_x_i = 1;
        tick();
        check("s_5xm10", after_sum_o_s, -50);
        check("u_5x246", after_sum_o_u, 1230);

        // Shadow load of 7 while active 2 keeps computing
        en_w_i = 1; w_i = 8'd2; swap_w_i = 1; en_x_i = 0;
        tick();
        swap_w_i = 0; x_i = 8'd4; en_x_i = 1; w_i = 8'd7;
        tick();
        check("shadow_ld_sum", after_sum_o_u, 8);
        en_w_i = 0;
        tick();
        check("shadow_hold_sum", after_sum_o_u, 8);
        swap_w_i = 1;
        tick();
        check("swap_cyc_sum", after_sum_o_u, 0);
        check("swap_cyc_valid", sum_valid_o_u, 0);
        swap_w_i = 0;
        tick();
        check("post_swap_sum", after_sum_o_u, 28);
        check("post_swap_valid", sum_valid_o_u, 1);

        // stop_mac is registered: it blocks the cycle after it is raised
        stop_mac_i = 1;
        tick();
        check("stop_first_sum", after_sum_o_u, 28);
        check("stop_mac_o", stop_mac_o_u, 1);
        x_i = 8'd9; w_i = 8'd11;
        tick();
        check("stop_sum", after_sum_o_u, 0);
        check("stop_valid", sum_valid_o_u, 0);
        check("stop_fwd_x", x_o_u, 9);
        check("stop_fwd_w", w_o_u, 11);
        stop_mac_i = 0; x_i = 8'd4;
        tick();
        check("stop_tail_sum", after_sum_o_u, 0);
        check("stop_clear_o", stop_mac_o_u, 0);
        tick();
        check("resume_sum", after_sum_o_u, 28);
        sum_valid_i = 0;
        tick();
        check("bubble_sum", after_sum_o_u, 0);
        check("bubble_valid", sum_valid_o_u, 0);
        sum_valid_i = 1; swap_w_i = 1; used_row_i = 0;
        tick();
        swap_w_i = 0;
        tick();
        check("unused_row_o", used_row_o_u, 0);
        check("unused_sum", after_sum_o_u, 0);
        check("unused_valid", sum_valid_o_u, 0);

        // 16-bit accumulator overflow, positive then negative
        before_sum_i = 32'd32000; en_w_i = 1; w_i = 8'd127; swap_w_i = 1; used_row_i = 1; en_x_i = 0;
        tick();
        check("n_pre_ovf", ovf_o_n, 0);
        en_w_i = 0; swap_w_i = 0; x_i = 8'd255; en_x_i = 1;
        tick();
        check("n_pos_ovf_sum", after_sum_o_n, SAT ? 32767 : -1151);
        check("n_pos_ovf_flag", ovf_o_n, SAT ? 1 : 0);
        en_x_i = 0;
        tick();
        check("n_ovf_sticky", ovf_o_n, SAT ? 1 : 0);
        check("n_idle_sum", after_sum_o_n, 0);
        en_w_i = 1; w_i = 8'h80; swap_w_i = 1;
        tick();
        check("n_swap_clr_ovf", ovf_o_n, 0);
        en_w_i = 0; swap_w_i = 0; before_sum_i = -32'sd32000; en_x_i = 1;
        tick();
        check("n_neg_ovf_sum", after_sum_o_n, SAT ? -32768 : 896);
        check("n_neg_ovf_flag", ovf_o_n, SAT ? 1 : 0);
        check("pre_rst_valid", sum_valid_o_u, 1);

        // Asynchronous reset mid-stream
        RSTN = 0;
        #1;
        check("arst_sum", after_sum_o_u, 0);
        check("arst_valid", sum_valid_o_u, 0);
        check("arst_x_o", x_o_u, 0);
        check("arst_used_row", used_row_o_u, 0);
        check("arst_ovf_n", ovf_o_n, 0);
        tick();
        check("arst_hold_valid", sum_valid_o_u, 0);
        RSTN = 1; x_i = 8'd4; before_sum_i = 0;
        tick();
        check("post_rst_sum", after_sum_o_u, 0);
        check("post_rst_valid", sum_valid_o_u, 0);
        en_w_i = 1; w_i = 8'd3; swap_w_i = 1; used_row_i = 1;
        tick();
        en_w_i = 0; swap_w_i = 0;
        tick();
        check("reload_sum", after_sum_o_u, 12);
        check("reload_valid", sum_valid_o_u, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
